// File: rtl/vga_hex_display.sv
`default_nettype none
// ============================================================================
//  Module   : vga_hex_display
//  Purpose  : Renders a 32-bit value as eight hex digits inside a text box on
//             a 640x480@60 Hz VGA raster.
//             This block owns the raster counters, a per-frame shadow copy of
//             the value, and a two-stage glyph fetch/render pipeline. An
//             external font block turns a nibble into a registered 7-column
//             glyph.
//  Ports    : clk, rst           - system clock, synchronous active-high reset
//             value[31:0]        - value to show; value[31:28] is the leftmost digit
//             font_data[3:0]     - nibble presented to the font block
//             font_col0..6[7:0]  - glyph columns, valid one clk after
//                                  font_data changes; bit0 = top row
//             hsync, vsync       - active-low syncs
//             vga_rgb[11:0]      - {R,G,B} pixel colour
//             frame_start        - one-clk pulse at the frame boundary
//  Revision : 1.0 - initial release
// ============================================================================
module vga_hex_display #(
  parameter int          CLK_DIV   = 4,
  parameter int          SCALE     = 4,
  parameter int          X0        = 192,
  parameter int          Y0        = 224,
  parameter logic [11:0] FG        = 12'hFFF,
  parameter logic [11:0] BG        = 12'h000,
  // Raster geometry; the defaults give standard 640x480@60 Hz timing.
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [3:0]  font_data,
  input  logic [7:0]  font_col0,
  input  logic [7:0]  font_col1,
  input  logic [7:0]  font_col2,
  input  logic [7:0]  font_col3,
  input  logic [7:0]  font_col4,
  input  logic [7:0]  font_col5,
  input  logic [7:0]  font_col6,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] vga_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [31:0] BOX_XL = 32'(X0);
  localparam logic [31:0] BOX_XH = 32'(X0 + 64 * SCALE);
  localparam logic [31:0] BOX_YL = 32'(Y0);
  localparam logic [31:0] BOX_YH = 32'(Y0 + 8 * SCALE);
  localparam logic [31:0] DIGIT_W = 32'(8 * SCALE);
  localparam logic [31:0] PIX_W   = 32'(SCALE);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [31:0]   shadow;

  // Stage 1 registers
  logic          s1_in_text;
  logic [2:0]    s1_c;
  logic [2:0]    s1_r;
  logic          s1_de;
  logic          s1_hs;
  logic          s1_vs;

  // --------------------------------------------------------------------------
  // Combinational decode of the current raster position
  // --------------------------------------------------------------------------
  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          hs_raw;
  logic          vs_raw;
  logic          de_raw;
  logic          in_text;
  logic [31:0]   hx;
  logic [31:0]   vy;
  logic [2:0]    dig_k;
  logic [2:0]    col_c;
  logic [2:0]    row_r;
  logic [3:0]    nibble;
  logic [7:0]    col_bits;
  logic          glyph_bit;

  assign tick   = (div == DW'(CLK_DIV - 1));
  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  assign hs_raw = !((h >= HW'(H_VISIBLE + H_FRONT)) &&
                    (h <  HW'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign vs_raw = !((v >= VW'(V_VISIBLE + V_FRONT)) &&
                    (v <  VW'(V_VISIBLE + V_FRONT + V_SYNC)));
  assign de_raw = (h < HW'(H_VISIBLE)) && (v < VW'(V_VISIBLE));

  assign in_text = (32'(h) >= BOX_XL) && (32'(h) < BOX_XH) &&
                   (32'(v) >= BOX_YL) && (32'(v) < BOX_YH);

  // Offsets are only meaningful inside the box; outside, in_text masks them.
  assign hx    = 32'(h) - BOX_XL;
  assign vy    = 32'(v) - BOX_YL;
  assign dig_k = 3'(hx / DIGIT_W);
  assign col_c = 3'(hx / PIX_W);
  assign row_r = 3'(vy / PIX_W);

  // Digit k lives at shadow[(7-k)*4 +: 4]; for a 3-bit k, 7-k is simply ~k.
  assign nibble = shadow[{~dig_k, 2'b00} +: 4];

  // Column 7 is the blank gap between characters.
  always_comb begin
    col_bits = 8'h00;
    case (s1_c)
      3'd0:    col_bits = font_col0;
      3'd1:    col_bits = font_col1;
      3'd2:    col_bits = font_col2;
      3'd3:    col_bits = font_col3;
      3'd4:    col_bits = font_col4;
      3'd5:    col_bits = font_col5;
      3'd6:    col_bits = font_col6;
      default: col_bits = 8'h00;
    endcase
  end

  assign glyph_bit = col_bits[s1_r];

  // --------------------------------------------------------------------------
  // Counters, shadow capture and the two pipeline stages.
  // The font block answers one clk after font_data moves; since a tick is at
  // least two clks apart, the columns are settled by the time stage 2 fires.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      shadow      <= 32'h0;
      s1_in_text  <= 1'b0;
      s1_c        <= 3'd0;
      s1_r        <= 3'd0;
      s1_de       <= 1'b0;
      // Syncs idle high so the first stage-2 load cannot emit a stray pulse.
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      font_data   <= 4'h0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vga_rgb     <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        div <= '0;

        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + VW'(1);
        end else begin
          h <= h + HW'(1);
        end

        // Latch the value only at the frame boundary so a frame never tears.
        if (h_last && v_last) begin
          shadow      <= value;
          frame_start <= 1'b1;
        end

        // Stage 1
        s1_in_text <= in_text;
        s1_c       <= col_c;
        s1_r       <= row_r;
        s1_de      <= de_raw;
        s1_hs      <= hs_raw;
        s1_vs      <= vs_raw;
        font_data  <= in_text ? nibble : 4'h0;

        // Stage 2
        hsync <= s1_hs;
        vsync <= s1_vs;
        if (!s1_de) begin
          vga_rgb <= 12'h000;
        end else if (s1_in_text && glyph_bit) begin
          vga_rgb <= FG;
        end else begin
          vga_rgb <= BG;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_hex_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_hex_display
//  Purpose  : Directed self-checking bench for vga_hex_display on a reduced
//             raster (160x22 total, 144x18 visible), SCALE=2, CLK_DIV=4.
//             Includes a registered 5x7 hex font model padded to 7 columns.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_hex_display;

  localparam int          CLK_DIV = 4;
  localparam int          SCALE   = 2;
  localparam int          X0      = 8;
  localparam int          Y0      = 1;
  localparam logic [11:0] FG      = 12'hF80;
  localparam logic [11:0] BG      = 12'h013;
  localparam int          HT      = 160;   // 144 + 4 + 8 + 4
  localparam int          VT      = 22;    // 18 + 1 + 2 + 1
  localparam int          FT      = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = 32'h0;
  logic [3:0]  font_data;
  logic [7:0]  fc0, fc1, fc2, fc3, fc4, fc5, fc6;
  logic        hsync, vsync, frame_start;
  logic [11:0] vga_rgb;

  int checks   = 0;
  int failures = 0;
  int ecount   = 0;   // posedges since reset release
  int cyc      = 0;   // absolute posedge count

  vga_hex_display #(
    .CLK_DIV(CLK_DIV), .SCALE(SCALE), .X0(X0), .Y0(Y0), .FG(FG), .BG(BG),
    .H_VISIBLE(144), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(18),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .font_data(font_data),
    .font_col0(fc0), .font_col1(fc1), .font_col2(fc2), .font_col3(fc3),
    .font_col4(fc4), .font_col5(fc5), .font_col6(fc6),
    .hsync(hsync), .vsync(vsync), .vga_rgb(vga_rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  // 5x7 glyph columns {c1,c2,c3,c4,c5}; c0 and c6 are blank padding.
  function automatic logic [39:0] glyph5(input logic [3:0] n);
    case (n)
      4'h0: glyph5 = 40'h3E_51_49_45_3E;
      4'h1: glyph5 = 40'h00_42_7F_40_00;
      4'h2: glyph5 = 40'h42_61_51_49_46;
      4'h3: glyph5 = 40'h21_41_45_4B_31;
      4'h4: glyph5 = 40'h18_14_12_7F_10;
      4'h5: glyph5 = 40'h27_45_45_45_39;
      4'h6: glyph5 = 40'h3C_4A_49_49_30;
      4'h7: glyph5 = 40'h01_71_09_05_03;
      4'h8: glyph5 = 40'h36_49_49_49_36;
      4'h9: glyph5 = 40'h06_49_49_29_1E;
      4'hA: glyph5 = 40'h7E_11_11_11_7E;
      4'hB: glyph5 = 40'h7F_49_49_49_36;
      4'hC: glyph5 = 40'h3E_41_41_41_22;
      4'hD: glyph5 = 40'h7F_41_41_41_3E;
      4'hE: glyph5 = 40'h7F_49_49_49_41;
      default: glyph5 = 40'h7F_09_09_09_01;
    endcase
  endfunction

  logic        font_ones = 1'b0;
  logic [39:0] glyph;
  always_comb glyph = glyph5(font_data);

  always @(posedge clk) begin
    fc0 <= font_ones ? 8'hFF : 8'h00;
    fc1 <= font_ones ? 8'hFF : glyph[39:32];
    fc2 <= font_ones ? 8'hFF : glyph[31:24];
    fc3 <= font_ones ? 8'hFF : glyph[23:16];
    fc4 <= font_ones ? 8'hFF : glyph[15:8];
    fc5 <= font_ones ? 8'hFF : glyph[7:0];
    fc6 <= font_ones ? 8'hFF : 8'h00;
  end

  // Pixel (x,y) of frame f reaches the outputs two ticks after the counters
  // sit on it; font_data for it appears one tick after.
  function automatic int pix_edge(input int f, input int x, input int y);
    return CLK_DIV * (f * FT + y * HT + x + 2);
  endfunction

  function automatic int fd_edge(input int f, input int x, input int y);
    return CLK_DIV * (f * FT + y * HT + x + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int n);
    while (ecount < n && cyc < 100000) @(negedge clk);
    if (ecount != n) begin
      checks++;
      failures++;
      $display("FAIL wait target=%0d reached=%0d", n, ecount);
    end
  endtask

  task automatic chk_pix(input int f, input int x, input int y,
                         input logic [11:0] rgb, input logic hs, input logic vs);
    wait_edge(pix_edge(f, x, y));
    chk($sformatf("rgb f%0d x%0d y%0d", f, x, y), 32'(vga_rgb), 32'(rgb));
    chk($sformatf("hsync f%0d x%0d y%0d", f, x, y), 32'(hsync), 32'(hs));
    chk($sformatf("vsync f%0d x%0d y%0d", f, x, y), 32'(vsync), 32'(vs));
  endtask

  task automatic chk_fd(input int f, input int x, input int y, input logic [3:0] exp);
    wait_edge(fd_edge(f, x, y));
    chk($sformatf("font_data f%0d x%0d y%0d", f, x, y), 32'(font_data), 32'(exp));
  endtask

  task automatic chk_fs(input int n, input logic exp);
    wait_edge(n);
    chk($sformatf("frame_start edge%0d", n), 32'(frame_start), 32'(exp));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " hsync"}, 32'(hsync), 32'd1);
    chk({tag, " vsync"}, 32'(vsync), 32'd1);
    chk({tag, " rgb"}, 32'(vga_rgb), 32'd0);
    chk({tag, " font_data"}, 32'(font_data), 32'd0);
    chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    // Frame 0: shadow is zero, timing of hsync/vsync
    chk_pix(0, 147, 0, 12'h000, 1'b1, 1'b1);
    chk_pix(0, 148, 0, 12'h000, 1'b0, 1'b1);
    chk_pix(0, 155, 0, 12'h000, 1'b0, 1'b1);
    chk_pix(0, 156, 0, 12'h000, 1'b1, 1'b1);
    chk_pix(0,   2, 1, BG,      1'b1, 1'b1);  // left of box
    chk_pix(0,  10, 1, BG,      1'b1, 1'b1);  // '0' col1 row0 clear
    chk_pix(0, 148, 1, 12'h000, 1'b0, 1'b1);  // next line's hsync
    chk_pix(0,  10, 3, FG,      1'b1, 1'b1);  // '0' col1 row1 set
    chk_pix(0, 159, 18, 12'h000, 1'b1, 1'b1);
    chk_pix(0,   0, 19, 12'h000, 1'b1, 1'b0);
    chk_pix(0, 159, 20, 12'h000, 1'b1, 1'b0);
    chk_pix(0,   0, 21, 12'h000, 1'b1, 1'b1);

    // Only the value present on the capture clk is taken
    value = 32'hDEADBEEF;
    chk_fs(CLK_DIV * FT - 1, 1'b0);
    value = 32'h1234ABCD;
    chk_fs(CLK_DIV * FT, 1'b1);
    chk_fs(CLK_DIV * FT + 1, 1'b0);

    // Frame 1: digit sequence on line Y0 plus glyph pixels of digit '1'
    chk_fd(1,   8, 0, 4'h0);
    chk_fd(1,   7, 1, 4'h0);
    chk_fd(1,   8, 1, 4'h1);
    chk_pix(1, 12, 1, BG, 1'b1, 1'b1);        // col2 row0
    chk_pix(1, 14, 1, FG, 1'b1, 1'b1);        // col3 row0
    chk_fd(1,  23, 1, 4'h1);
    chk_fd(1,  24, 1, 4'h2);
    chk_fd(1,  40, 1, 4'h3);
    chk_fd(1,  56, 1, 4'h4);
    chk_fd(1,  72, 1, 4'hA);
    chk_fd(1,  88, 1, 4'hB);
    chk_fd(1, 104, 1, 4'hC);
    chk_fd(1, 120, 1, 4'hD);
    chk_fd(1, 135, 1, 4'hD);
    chk_fd(1, 136, 1, 4'h0);
    chk_pix(1, 12, 3, FG, 1'b1, 1'b1);        // col2 row1
    chk_pix(1, 22, 5, BG, 1'b1, 1'b1);        // column 7 gap

    // Mid-frame value change must not show before the next frame
    wait_edge(fd_edge(1, 0, 9));
    value = 32'h10000000;
    chk_pix(1,  14, 14, FG, 1'b1, 1'b1);      // col3 row6
    chk_fd(1,   24, 14, 4'h2);
    chk_fd(1,  120, 14, 4'hD);
    chk_pix(1,  15, 15, BG, 1'b1, 1'b1);      // row 7 blank
    chk_fs(2 * CLK_DIV * FT, 1'b1);

    // Frame 2: new digits
    chk_fd(2,   8, 1, 4'h1);
    chk_fd(2,  24, 1, 4'h0);
    chk_fd(2, 120, 1, 4'h0);

    // All-ones font: box fully lit except column 7; blanking forces black
    wait_edge(fd_edge(2, 0, 4));
    font_ones = 1'b1;
    chk_pix(2,   7, 5, BG,      1'b1, 1'b1);
    chk_pix(2,   8, 5, FG,      1'b1, 1'b1);
    chk_pix(2,  22, 5, BG,      1'b1, 1'b1);
    chk_pix(2,  23, 5, BG,      1'b1, 1'b1);
    chk_pix(2,  24, 5, FG,      1'b1, 1'b1);
    chk_pix(2, 136, 5, BG,      1'b1, 1'b1);
    chk_pix(2, 144, 5, 12'h000, 1'b1, 1'b1);
    chk_pix(2,   8, 16, FG,     1'b1, 1'b1);  // row 7 from bit7
    chk_pix(2,  10, 17, BG,     1'b1, 1'b1);
    chk_pix(2,  10, 18, 12'h000, 1'b1, 1'b1);
    font_ones = 1'b0;

    // One-clk reset in the vsync region
    wait_edge(fd_edge(2, 100, 20));
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midreset");
    rst = 1'b0;
    chk_pix(0, 147, 0, 12'h000, 1'b1, 1'b1);
    chk_pix(0, 148, 0, 12'h000, 1'b0, 1'b1);
    chk_fd(0,   8, 1, 4'h0);
    chk_pix(0,  10, 3, FG, 1'b1, 1'b1);       // '0' glyph again

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
